// File: rtl/aes_stream_arbiter.sv
// Round-robin message arbiter in front of a single in-order AES engine.
// Engine results are routed back to the source channel through an ID FIFO kept in grant order.
`default_nettype none

module aes_stream_arbiter #(
    parameter int NUM_CH        = 4,
    parameter int DATA_WIDTH    = 128,
    parameter int ID_FIFO_DEPTH = 4,
    localparam int CH_W         = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            s_tvalid,
    output logic [NUM_CH-1:0]            s_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CH-1:0]            s_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic                         m_tlast,
    output logic [CH_W-1:0]              m_tid,
    input  logic                         r_tvalid,
    output logic                         r_tready,
    input  logic [DATA_WIDTH-1:0]        r_tdata,
    input  logic                         r_tlast,
    output logic [NUM_CH-1:0]            o_tvalid,
    input  logic [NUM_CH-1:0]            o_tready,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_tdata,
    output logic [NUM_CH-1:0]            o_tlast,
    output logic                         busy
);

    localparam int PTR_W = $clog2(ID_FIFO_DEPTH);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] arb_idx;
    logic            arb_found;
    logic [CH_W-1:0] head;

    logic [CH_W-1:0]  id_mem [ID_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic msg_done;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
    endfunction

    // Search starts one past the previous winner, so the last served channel has lowest priority.
    always_comb begin : arb_search
        logic [CH_W-1:0] cand;
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = last_grant;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = next_ch(cand);
            if (!arb_found && s_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Fullness comes from the registered count only; a same-cycle pop never opens a grant.
    assign fifo_full  = (count == (PTR_W + 1)'(ID_FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = (state == IDLE) && arb_found && !fifo_full;
    assign head       = id_mem[rd_ptr];

    always_comb begin : m_path
        s_tready = '0;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        m_tid    = '0;
        if (state == LOCK) begin
            m_tvalid        = s_tvalid[grant];
            m_tdata         = s_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
            m_tlast         = s_tlast[grant];
            m_tid           = grant;
            s_tready[grant] = m_tready;
        end
    end

    assign msg_done = (state == LOCK) && m_tvalid && m_tready && m_tlast;

    always_comb begin : r_path
        o_tvalid = '0;
        o_tdata  = '0;
        o_tlast  = '0;
        r_tready = 1'b0;
        if (!fifo_empty) begin
            o_tvalid[head]                           = r_tvalid;
            o_tdata[head*DATA_WIDTH +: DATA_WIDTH]   = r_tdata;
            o_tlast[head]                            = r_tlast;
            r_tready                                 = o_tready[head];
        end
    end

    assign pop  = !fifo_empty && r_tvalid && r_tready && r_tlast;
    assign busy = (state == LOCK) || !fifo_empty;

    // NOTE: registered state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            case (state)
                IDLE: if (push) begin
                    grant <= arb_idx;
                    state <= LOCK;
                end
                LOCK: if (msg_done) begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: ID storage is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) id_mem[wr_ptr] <= arb_idx;
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_stream_arbiter.sv
// Directed bench for aes_stream_arbiter: bubble/lock timing, round-robin fairness,
// ID FIFO full and wrap, result routing with backpressure, and mid-message reset.
module tb_aes_stream_arbiter;

    localparam int NUM_CH = 4;
    localparam int DW     = 128;
    localparam int DEPTH  = 4;
    localparam int CH_W   = 2;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic [NUM_CH-1:0]       s_tvalid;
    logic [NUM_CH-1:0]       s_tready;
    logic [NUM_CH*DW-1:0]    s_tdata;
    logic [NUM_CH-1:0]       s_tlast;
    logic                    m_tvalid;
    logic                    m_tready;
    logic [DW-1:0]           m_tdata;
    logic                    m_tlast;
    logic [CH_W-1:0]         m_tid;
    logic                    r_tvalid;
    logic                    r_tready;
    logic [DW-1:0]           r_tdata;
    logic                    r_tlast;
    logic [NUM_CH-1:0]       o_tvalid;
    logic [NUM_CH-1:0]       o_tready;
    logic [NUM_CH*DW-1:0]    o_tdata;
    logic [NUM_CH-1:0]       o_tlast;
    logic                    busy;

    aes_stream_arbiter #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ID_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tid(m_tid),
        .r_tvalid(r_tvalid), .r_tready(r_tready), .r_tdata(r_tdata), .r_tlast(r_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata), .o_tlast(o_tlast),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int msg_left [NUM_CH];
    int beats    [NUM_CH];
    int bidx     [NUM_CH];
    bit auto_drain = 1'b0;

    int beat_log[$];
    int msg_log[$];
    int res_log[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int ch, input int b);
        return DW'(32'h5A00_0000 + ch * 256 + b);
    endfunction

    // Sources present their current beat; the optional drain keeps the result side always ready.
    task automatic drive_sources();
        for (int k = 0; k < NUM_CH; k++) begin
            s_tvalid[k]        = (msg_left[k] > 0);
            s_tlast[k]         = (bidx[k] == beats[k] - 1);
            s_tdata[k*DW +: DW] = beat_data(k, bidx[k]);
        end
        if (auto_drain) begin
            r_tvalid = 1'b1;
            r_tlast  = 1'b1;
            r_tdata  = DW'(32'hD0D0);
            o_tready = '1;
        end
        #1;
    endtask

    task automatic load(input int ch, input int n_msgs, input int n_beats);
        msg_left[ch] += n_msgs;
        beats[ch]     = n_beats;
        drive_sources();
    endtask

    task automatic clear_model();
        for (int k = 0; k < NUM_CH; k++) begin
            msg_left[k] = 0;
            beats[k]    = 1;
            bidx[k]     = 0;
        end
        beat_log.delete();
        msg_log.delete();
        res_log.delete();
    endtask

    // Handshakes are sampled mid-cycle, then the clock advances and the sources step.
    task automatic clk_cycle();
        logic [NUM_CH-1:0] acc;
        acc = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            beat_log.push_back(int'(m_tid));
            if (m_tlast) msg_log.push_back(int'(m_tid));
        end
        if (r_tvalid && r_tready && r_tlast)
            for (int k = 0; k < NUM_CH; k++)
                if (o_tvalid[k]) res_log.push_back(k);
        @(posedge clk);
        #2;
        for (int k = 0; k < NUM_CH; k++) begin
            if (acc[k]) begin
                if (bidx[k] == beats[k] - 1) begin
                    bidx[k] = 0;
                    msg_left[k]--;
                end else begin
                    bidx[k]++;
                end
            end
        end
        drive_sources();
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        auto_drain = 1'b0;
        m_tready   = 1'b1;
        r_tvalid   = 1'b0;
        r_tlast    = 1'b0;
        r_tdata    = '0;
        o_tready   = '0;
        clear_model();
        drive_sources();
        clk_cycle();
        clk_cycle();
        resetn = 1'b1;
        clear_model();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn     = 1'b0;
        m_tready   = 1'b1;
        r_tvalid   = 1'b0;
        r_tlast    = 1'b0;
        r_tdata    = '0;
        o_tready   = '0;
        clear_model();
        drive_sources();
        clk_cycle();
        clk_cycle();

        check("rst_s_tready", DW'(s_tready), DW'(0));
        check("rst_o_tvalid", DW'(o_tvalid), DW'(0));
        check("rst_m_tvalid", DW'(m_tvalid), DW'(0));
        check("rst_r_tready", DW'(r_tready), DW'(0));
        check("rst_busy",     DW'(busy),     DW'(0));
        check("rst_m_tid",    DW'(m_tid),    DW'(0));
        check("rst_count",    DW'(dut.count), DW'(0));
        resetn = 1'b1;
        #1;

        // Single channel: one bubble, then three beats tagged with channel 2.
        load(2, 1, 3);
        check("t26_bubble_mvalid", DW'(m_tvalid), DW'(0));
        check("t26_bubble_sready", DW'(s_tready), DW'(0));
        clk_cycle();
        for (int b = 0; b < 3; b++) begin
            check("t26_mvalid", DW'(m_tvalid), DW'(1));
            check("t26_mtid",   DW'(m_tid),    DW'(2));
            check("t26_mdata",  m_tdata,       beat_data(2, b));
            check("t26_mlast",  DW'(m_tlast),  DW'(b == 2));
            check("t26_sready", DW'(s_tready), DW'(4'b0100));
            clk_cycle();
        end
        check("t26_idle_mvalid", DW'(m_tvalid),  DW'(0));
        check("t26_idle_sready", DW'(s_tready),  DW'(0));
        check("t26_busy",        DW'(busy),      DW'(1));
        check("t26_count",       DW'(dut.count), DW'(1));
        r_tvalid = 1'b1;
        r_tlast  = 1'b1;
        r_tdata  = DW'(32'hC0FFEE);
        o_tready = 4'b0100;
        #1;
        check("t26_o_tvalid", DW'(o_tvalid), DW'(4'b0100));
        check("t26_o_tlast",  DW'(o_tlast),  DW'(4'b0100));
        check("t26_r_tready", DW'(r_tready), DW'(1));
        check("t26_o_tdata",  o_tdata[2*DW +: DW], DW'(32'hC0FFEE));
        clk_cycle();
        r_tvalid = 1'b0;
        r_tlast  = 1'b0;
        #1;
        check("t26_drained_busy",  DW'(busy),      DW'(0));
        check("t26_drained_count", DW'(dut.count), DW'(0));
        check("t26_drained_rrdy",  DW'(r_tready),  DW'(0));

        // Fairness: four 2-beat messages at once -> 0,0,1,1,2,2,3,3 in 12 cycles.
        do_reset();
        auto_drain = 1'b1;
        for (int k = 0; k < NUM_CH; k++) load(k, 1, 2);
        for (int c = 0; c < 12; c++) clk_cycle();
        check("t27_beats", DW'(beat_log.size()), DW'(8));
        for (int i = 0; i < 8; i++)
            if (i < beat_log.size()) check("t27_beat_tid", DW'(beat_log[i]), DW'(i / 2));
        for (int k = 0; k < NUM_CH; k++) load(k, 1, 1);
        for (int c = 0; c < 10; c++) clk_cycle();
        check("t27_msgs", DW'(msg_log.size()), DW'(8));
        for (int i = 0; i < 8; i++)
            if (i < msg_log.size()) check("t27_msg_order", DW'(msg_log[i]), DW'(i % 4));
        check("t27_results", DW'(res_log.size()), DW'(8));
        for (int i = 0; i < 8; i++)
            if (i < res_log.size()) check("t27_res_order", DW'(res_log[i]), DW'(i % 4));

        // FIFO full: the fifth message waits until a result pops an ID.
        do_reset();
        load(0, 2, 1);
        for (int k = 1; k < NUM_CH; k++) load(k, 1, 1);
        for (int c = 0; c < 10; c++) clk_cycle();
        check("t28_granted", DW'(msg_log.size()), DW'(4));
        for (int i = 0; i < 4; i++)
            if (i < msg_log.size()) check("t28_order", DW'(msg_log[i]), DW'(i));
        check("t28_count_full", DW'(dut.count), DW'(DEPTH));
        check("t28_wait_mvalid", DW'(m_tvalid), DW'(0));
        check("t28_wait_sready", DW'(s_tready), DW'(0));
        r_tvalid = 1'b1;
        r_tlast  = 1'b1;
        r_tdata  = DW'(32'hAA00);
        o_tready = '1;
        #1;
        check("t28_pop_ovalid", DW'(o_tvalid), DW'(4'b0001));
        check("t28_pop_rready", DW'(r_tready), DW'(1));
        clk_cycle();
        r_tvalid = 1'b0;
        r_tlast  = 1'b0;
        #1;
        check("t28_after_pop_count",  DW'(dut.count), DW'(3));
        check("t28_after_pop_bubble", DW'(m_tvalid),  DW'(0));
        clk_cycle();
        check("t28_fifth_mvalid", DW'(m_tvalid), DW'(1));
        check("t28_fifth_mtid",   DW'(m_tid),    DW'(0));
        clk_cycle();
        check("t28_refill_count", DW'(dut.count), DW'(DEPTH));

        // Routing and backpressure with IDs 1,3 outstanding.
        do_reset();
        load(1, 1, 1);
        load(3, 1, 1);
        for (int c = 0; c < 4; c++) clk_cycle();
        check("t29_count", DW'(dut.count), DW'(2));
        check("t29_msgs",  DW'(msg_log.size()), DW'(2));
        if (msg_log.size() == 2) begin
            check("t29_first",  DW'(msg_log[0]), DW'(1));
            check("t29_second", DW'(msg_log[1]), DW'(3));
        end
        r_tvalid = 1'b1;
        r_tlast  = 1'b1;
        r_tdata  = DW'(32'hD1);
        o_tready = 4'b1101;
        load(0, 1, 1);
        check("t29_stall_rready", DW'(r_tready), DW'(0));
        check("t29_stall_ovalid", DW'(o_tvalid), DW'(4'b0010));
        check("t29_stall_odata",  o_tdata[1*DW +: DW], DW'(32'hD1));
        clk_cycle();
        check("t29_arb_mvalid", DW'(m_tvalid), DW'(1));
        check("t29_arb_mtid",   DW'(m_tid),    DW'(0));
        check("t29_arb_rready", DW'(r_tready), DW'(0));
        clk_cycle();
        check("t29_count3", DW'(dut.count), DW'(3));
        o_tready = '1;
        #1;
        check("t29_go_rready", DW'(r_tready), DW'(1));
        clk_cycle();
        r_tdata = DW'(32'hD3);
        #1;
        check("t29_ch3_ovalid", DW'(o_tvalid), DW'(4'b1000));
        check("t29_ch3_odata",  o_tdata[3*DW +: DW], DW'(32'hD3));
        clk_cycle();
        check("t29_ch0_ovalid", DW'(o_tvalid), DW'(4'b0001));
        clk_cycle();
        r_tvalid = 1'b0;
        r_tlast  = 1'b0;
        #1;
        check("t29_end_count", DW'(dut.count), DW'(0));
        check("t29_end_busy",  DW'(busy),      DW'(0));
        check("t29_results",   DW'(res_log.size()), DW'(3));
        if (res_log.size() == 3) begin
            check("t29_res0", DW'(res_log[0]), DW'(1));
            check("t29_res1", DW'(res_log[1]), DW'(3));
            check("t29_res2", DW'(res_log[2]), DW'(0));
        end

        // Push and pop together at count DEPTH-1, then 12 more messages wrap the pointers.
        do_reset();
        for (int k = 0; k < 3; k++) load(k, 1, 1);
        for (int c = 0; c < 6; c++) clk_cycle();
        check("t30_count_pre", DW'(dut.count), DW'(DEPTH - 1));
        r_tvalid = 1'b1;
        r_tlast  = 1'b1;
        r_tdata  = DW'(32'hE0);
        o_tready = '1;
        load(3, 1, 1);
        check("t30_same_rready", DW'(r_tready), DW'(1));
        check("t30_same_mvalid", DW'(m_tvalid), DW'(0));
        clk_cycle();
        check("t30_count_same", DW'(dut.count), DW'(DEPTH - 1));
        check("t30_granted3",   DW'(m_tid),     DW'(3));
        auto_drain = 1'b1;
        for (int k = 0; k < NUM_CH; k++) load(k, 3, 1);
        for (int c = 0; c < 40; c++) clk_cycle();
        check("t30_results", DW'(res_log.size()), DW'(4 * DEPTH));
        for (int i = 0; i < 4 * DEPTH; i++)
            if (i < res_log.size()) check("t30_res_order", DW'(res_log[i]), DW'(i % 4));
        check("t30_end_count", DW'(dut.count),  DW'(0));
        check("t30_end_busy",  DW'(busy),       DW'(0));
        check("t30_wr_ptr",    DW'(dut.wr_ptr), DW'(0));
        check("t30_rd_ptr",    DW'(dut.rd_ptr), DW'(0));

        // Reset during beat 2 of 4 after channel 0 was served; channel 0 must still win afterwards.
        auto_drain = 1'b0;
        r_tvalid   = 1'b0;
        r_tlast    = 1'b0;
        o_tready   = '0;
        clear_model();
        load(0, 1, 1);
        load(1, 1, 4);
        for (int c = 0; c < 4; c++) clk_cycle();
        check("t31_beat2_mtid",  DW'(m_tid),   DW'(1));
        check("t31_beat2_mdata", m_tdata,      beat_data(1, 1));
        resetn = 1'b0;
        clk_cycle();
        check("t31_rst_sready", DW'(s_tready),  DW'(0));
        check("t31_rst_mvalid", DW'(m_tvalid),  DW'(0));
        check("t31_rst_ovalid", DW'(o_tvalid),  DW'(0));
        check("t31_rst_rready", DW'(r_tready),  DW'(0));
        check("t31_rst_busy",   DW'(busy),      DW'(0));
        check("t31_rst_mtid",   DW'(m_tid),     DW'(0));
        check("t31_rst_count",  DW'(dut.count), DW'(0));
        resetn = 1'b1;
        clear_model();
        load(0, 1, 1);
        load(1, 1, 1);
        check("t31_post_bubble", DW'(m_tvalid), DW'(0));
        clk_cycle();
        check("t31_post_mvalid", DW'(m_tvalid), DW'(1));
        check("t31_post_mtid",   DW'(m_tid),    DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_stream_arbiter.md
AES_STREAM_ARBITER -- requirements
Module: aes_stream_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk and resetn; all state SHALL update on the rising edge of clk.
REQ-002 Parameter NUM_CH, default 4, SHALL set the number of input/output channels; the legal range is 2..8.
REQ-003 Parameter DATA_WIDTH, default 128, SHALL set the per-beat payload width, one AES block.
REQ-004 Parameter ID_FIFO_DEPTH, default 4, SHALL set the maximum number of messages outstanding in the engine; it SHALL be a power of 2 and at least 2.
REQ-005 Local parameter CH_W SHALL equal clogb2(NUM_CH).
REQ-006 Ports SHALL be, in this order:
- clk in 1
- resetn in 1
- s_tvalid in NUM_CH
- s_tready out NUM_CH
- s_tdata in NUM_CH*DATA_WIDTH (channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH])
- s_tlast in NUM_CH
- m_tvalid out 1, m_tready in 1, m_tdata out DATA_WIDTH, m_tlast out 1, m_tid out CH_W (to the AES processing stage)
- r_tvalid in 1, r_tready out 1, r_tdata in DATA_WIDTH, r_tlast in 1 (results from the AES processing stage)
- o_tvalid out NUM_CH, o_tready in NUM_CH, o_tdata out NUM_CH*DATA_WIDTH, o_tlast out NUM_CH
- busy out 1 (high while a message is locked or the ID FIFO is not empty)

Function
REQ-007 A message SHALL be every beat on a channel from the command word through the beat with s_tlast=1; messages SHALL never interleave on the m_* port.
REQ-008 The state machine SHALL have two states, IDLE and LOCK.
REQ-009 In IDLE, if any s_tvalid bit is 1 and the ID FIFO is not full, the block SHALL grant the first requesting channel after last_grant in ascending modulo order and SHALL enter LOCK on the next edge.
REQ-010 On that grant the block SHALL load the granted channel into the grant register and push its index into the ID FIFO.
REQ-011 In IDLE, s_tready and m_tvalid SHALL be all zero, so there is a one-cycle arbitration bubble per message.
REQ-012 In LOCK with granted channel g:
- m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], m_tlast=s_tlast[g], m_tid=g, all combinational;
- s_tready[g]=m_tready;
- all other s_tready bits SHALL be 0.
REQ-013 In LOCK, a handshake with m_tlast=1 SHALL set last_grant to g and return the state machine to IDLE.
REQ-014 Fullness SHALL be taken from the registered count; a pop in the same cycle SHALL NOT enable a grant.
REQ-015 The ID FIFO head h SHALL route results:
- o_tvalid[h]=r_tvalid;
- o_tdata[h]=r_tdata, o_tlast[h]=r_tlast;
- r_tready=o_tready[h];
- all other o_tvalid bits SHALL be 0.
REQ-016 When the ID FIFO is empty, r_tready and every o_tvalid bit SHALL be 0.
REQ-017 A result handshake with r_tlast=1 SHALL pop the ID FIFO.
REQ-018 A simultaneous push and pop SHALL leave the count unchanged and update both pointers.
REQ-019 The FIFO pointers SHALL wrap modulo ID_FIFO_DEPTH.
REQ-020 The count SHALL have clogb2(ID_FIFO_DEPTH)+1 bits and SHALL never exceed ID_FIFO_DEPTH or go below 0.
REQ-021 Results SHALL be returned in grant order; the engine is single-stream and in-order.
REQ-022 A stalled o_tready on the head channel SHALL NOT block input arbitration.

Reset
REQ-023 While resetn=0 the block SHALL set state=IDLE, last_grant=NUM_CH-1 (channel 0 wins first), FIFO pointers and count to 0, and grant to 0.
REQ-024 After reset, all s_tready, o_tvalid, m_tvalid, r_tready and busy outputs SHALL be 0, and m_tid SHALL be 0.
REQ-025 Reset asserted mid-message SHALL abandon the locked message and flush all outstanding IDs, with no partial state retained.

Verification
REQ-026 Single channel: channel 2 sends 3 beats (last on beat 3) with m_tready=1 -> one bubble cycle, then m_tid=2 for 3 consecutive beats; IDLE is re-entered after the third beat.
REQ-027 Fairness: channels 0..3 each present a 2-beat message at cycle 0 -> grant order 0,1,2,3 and 8 beats over 12 cycles; a repeated request pattern then continues 0,1,...
REQ-028 FIFO full: r_tvalid is held at 0 while 5 single-beat messages are offered -> 4 are granted and the 5th waits; one r_tlast handshake lets the 5th be granted on the following IDLE cycle.
REQ-029 Routing and backpressure: with FIFO holding IDs 1,3 and o_tready[1]=0 -> r_tready=0 and inputs still arbitrate; raising o_tready[1] delivers channel 1's result, then channel 3's.
REQ-030 Simultaneous push and pop at count=ID_FIFO_DEPTH-1 -> count is unchanged, and the pointers wrap correctly over 3*ID_FIFO_DEPTH messages.
REQ-031 Reset mid-message: resetn=0 during beat 2 of 4 -> on the next cycle all outputs are 0, count=0, and channel 0 is granted first after release.
